// File: rtl/count_seg_pkg.sv
// ---------------------------------------------------------------------------
// count_seg_pkg
// Shared types and constants for the count_seg_display block.
//   digit_state_t : which display digit owns the current refresh slot
//   SEG_0..SEG_9  : active-high seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_OFF       : all segments dark
// ---------------------------------------------------------------------------
package count_seg_pkg;

   typedef enum logic {
      ONES = 1'b0,
      TENS = 1'b1
   } digit_state_t;

   localparam logic [6:0] SEG_0   = 7'h3F;
   localparam logic [6:0] SEG_1   = 7'h06;
   localparam logic [6:0] SEG_2   = 7'h5B;
   localparam logic [6:0] SEG_3   = 7'h4F;
   localparam logic [6:0] SEG_4   = 7'h66;
   localparam logic [6:0] SEG_5   = 7'h6D;
   localparam logic [6:0] SEG_6   = 7'h7D;
   localparam logic [6:0] SEG_7   = 7'h07;
   localparam logic [6:0] SEG_8   = 7'h7F;
   localparam logic [6:0] SEG_9   = 7'h6F;
   localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/count_seg_display_seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational BCD digit to seven-segment pattern (active-high).
//   digit   in  4  BCD digit; 10..15 never occur and decode to all-off
//   pattern out 7  segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_decode
   import count_seg_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] pattern
);

   always_comb begin
      pattern = SEG_OFF;
      case (digit)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/count_seg_display.sv
// ---------------------------------------------------------------------------
// count_seg_display
// Samples a 4-bit binary count, splits it into tens/ones decimal digits and
// time-multiplexes them onto a 2-digit seven-segment display. Also pulses on
// value change and on 15->0 wrap of the captured value.
//
// Parameters:
//   REFRESH_DIV    clocks per digit slot (>= 2)
//   SEG_ACTIVE_LOW 1: seg output inverted (lit segment = 0)
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  when defined, the tens digit is blanked (an=00,
//                          seg dark) whenever it is zero; slot timing unchanged.
// Ports:
//   clk        in   1  clock, posedge
//   rst        in   1  synchronous reset, active-high
//   q_in       in   4  binary count from the upstream counter
//   hold       in   1  1: keep the last captured value
//   seg        out  7  segments {g,f,e,d,c,b,a}
//   an         out  2  digit enables, an[0]=ones, an[1]=tens (active-high)
//   chg        out  1  one-cycle pulse: new capture differs from previous
//   wrap       out  1  one-cycle pulse: capture went 15 -> 0
//   state_dbg  out  1  current refresh FSM state (observation only)
//
// Handshake: none; q_in is sampled unconditionally every cycle hold is low.
// ---------------------------------------------------------------------------
module count_seg_display
   import count_seg_pkg::*;
#(
   parameter int REFRESH_DIV    = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b0
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   q_in,
   input  logic         hold,
   output logic [6:0]   seg,
   output logic [1:0]   an,
   output logic         chg,
   output logic         wrap,
   output digit_state_t state_dbg
);

   localparam int              CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]   DIV_LAST = CW'(REFRESH_DIV - 1);
   // Reset value of seg is "all off" in the output polarity.
   localparam logic [6:0]      SEG_RST  = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

   // ---------------- state ----------------
   logic [3:0]    cap_q,     cap_d;
   logic [CW-1:0] div_cnt_q, div_cnt_d;
   digit_state_t  state_q,   state_d;
   logic [6:0]    seg_q,     seg_d;
   logic [1:0]    an_q,      an_d;
   logic          chg_q,     chg_d;
   logic          wrap_q,    wrap_d;

   // ---------------- datapath helpers ----------------
   logic          ge_ten;
   logic [3:0]    tens_digit;
   logic [3:0]    ones_digit;
   logic [3:0]    sel_digit;
   logic [6:0]    dec_pattern;
   logic          slot_end;

   // Capture register and change/wrap detection.
   always_comb begin
      cap_d  = cap_q;
      chg_d  = 1'b0;
      wrap_d = 1'b0;
      if (!hold) begin
         cap_d  = q_in;
         chg_d  = (q_in != cap_q);
         wrap_d = (cap_q == 4'd15) && (q_in == 4'd0);
      end
   end

   // Values 0..15 only need a 0/1 tens digit, so a compare replaces a divide.
   always_comb begin
      ge_ten     = (cap_q >= 4'd10);
      tens_digit = {3'b000, ge_ten};
      ones_digit = ge_ten ? (cap_q - 4'd10) : cap_q;
   end

   // Refresh divider: slot_end marks the last cycle of a digit slot.
   always_comb begin
      slot_end  = (div_cnt_q == DIV_LAST);
      div_cnt_d = slot_end ? '0 : (div_cnt_q + 1'b1);
   end

   // FSM process 1: state register (with all other flops).
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_q     <= 4'd0;
         div_cnt_q <= '0;
         state_q   <= ONES;
         seg_q     <= SEG_RST;
         an_q      <= 2'b00;
         chg_q     <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         cap_q     <= cap_d;
         div_cnt_q <= div_cnt_d;
         state_q   <= state_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
         chg_q     <= chg_d;
         wrap_q    <= wrap_d;
      end
   end

   // FSM process 2: next state. Strict ONES <-> TENS alternation.
   always_comb begin
      state_d = state_q;
      if (slot_end) begin
         case (state_q)
            ONES:    state_d = TENS;
            TENS:    state_d = ONES;
            default: state_d = ONES;
         endcase
      end
   end

   // Digit mux feeding the single shared decoder.
   always_comb begin
      sel_digit = (state_q == TENS) ? tens_digit : ones_digit;
   end

   seg7_decode u_decode (
      .digit   (sel_digit),
      .pattern (dec_pattern)
   );

   // FSM process 3: outputs, registered next cycle.
   always_comb begin
      logic [6:0] pat;
      pat  = dec_pattern;
      an_d = 2'b01;
      case (state_q)
         ONES: an_d = 2'b01;
         TENS: begin
            an_d = 2'b10;
`ifdef LEADING_ZERO_BLANK_EN
            if (tens_digit == 4'd0) begin
               an_d = 2'b00;
               pat  = SEG_OFF;
            end
`endif
         end
         default: an_d = 2'b00;
      endcase
      // Polarity is handled only here so the decoder stays active-high.
      seg_d = SEG_ACTIVE_LOW ? ~pat : pat;
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign chg       = chg_q;
   assign wrap      = wrap_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_count_seg_display.sv
module tb_count_seg_display;
  import count_seg_pkg::*;

  localparam int DIV = 4;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         hold = 1'b0;
  logic [3:0]   q_in = 4'd0;
  logic [6:0]   seg;
  logic [1:0]   an;
  logic         chg;
  logic         wrap;
  digit_state_t state_dbg;

  count_seg_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .q_in      (q_in),
    .hold      (hold),
    .seg       (seg),
    .an        (an),
    .chg       (chg),
    .wrap      (wrap),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Display = tens/ones of the captured value; slot index = edges since reset / DIV.
  logic [6:0] seg_tab [0:9];
  int         m_cap = 0;
  int         m_n   = 0;
  logic [6:0] e_seg;
  logic [1:0] e_an;
  logic       e_chg, e_wrap, e_tens_state;

  task automatic model(input logic r, input logic h, input logic [3:0] q);
    int digit;
    if (r) begin
      e_seg = 7'h00; e_an = 2'b00; e_chg = 1'b0; e_wrap = 1'b0;
      m_cap = 0; m_n = 0;
    end else begin
      if (((m_n / DIV) % 2) == 1) begin
        digit = m_cap / 10;
        e_an  = 2'b10;
        e_seg = seg_tab[digit];
`ifdef LEADING_ZERO_BLANK_EN
        if (digit == 0) begin
          e_an  = 2'b00;
          e_seg = 7'h00;
        end
`endif
      end else begin
        digit = m_cap % 10;
        e_an  = 2'b01;
        e_seg = seg_tab[digit];
      end
      e_chg  = !h && (int'(q) != m_cap);
      e_wrap = !h && (m_cap == 15) && (q == 4'd0);
      if (!h) m_cap = int'(q);
      m_n++;
    end
    e_tens_state = (((m_n / DIV) % 2) == 1);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic h, input logic [3:0] q);
    rst = r; hold = h; q_in = q;
    @(posedge clk);
    model(r, h, q);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".seg"},   {1'b0, seg},  {1'b0, e_seg});
    check({tag, ".an"},    {6'd0, an},   {6'd0, e_an});
    check({tag, ".chg"},   {7'd0, chg},  {7'd0, e_chg});
    check({tag, ".wrap"},  {7'd0, wrap}, {7'd0, e_wrap});
    check({tag, ".state"}, {7'd0, (state_dbg == TENS)}, {7'd0, e_tens_state});
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       rst;
    logic       hold;
    logic [3:0] q;
    logic [6:0] seg;
    logic [1:0] an;
    logic       chg;
    logic       wrap;
  } vec_t;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] T0_SEG = 7'h00;
  localparam logic [1:0] T0_AN  = 2'b00;
`else
  localparam logic [6:0] T0_SEG = 7'h3F;
  localparam logic [1:0] T0_AN  = 2'b10;
`endif

  vec_t vecs [12];

  initial begin
    int wrap_seen;
    logic [3:0] rq;
    logic rr, rh;

    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;

    // Reset two cycles, then q_in=7 steady: first edge shows cap 0 in ONES slot.
    vecs[0]  = '{1'b1, 1'b0, 4'd0, 7'h00, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'd0, 7'h00, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'd7, 7'h3F, 2'b01, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'd7, 7'h07, 2'b01, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'd7, 7'h07, 2'b01, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'd7, 7'h07, 2'b01, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'd7, T0_SEG, T0_AN, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'd7, T0_SEG, T0_AN, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'd7, T0_SEG, T0_AN, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'd7, T0_SEG, T0_AN, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'd7, 7'h07, 2'b01, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'd7, 7'h07, 2'b01, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].hold, vecs[i].q);
      check($sformatf("tbl%0d.seg", i),  {1'b0, seg},  {1'b0, vecs[i].seg});
      check($sformatf("tbl%0d.an", i),   {6'd0, an},   {6'd0, vecs[i].an});
      check($sformatf("tbl%0d.chg", i),  {7'd0, chg},  {7'd0, vecs[i].chg});
      check($sformatf("tbl%0d.wrap", i), {7'd0, wrap}, {7'd0, vecs[i].wrap});
    end

    // q_in=13: ones slot shows 3, tens slot shows 1.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 4'd13);
      check_model("q13");
      if (i >= 2) begin
        if (an == 2'b01) check("q13.ones", {1'b0, seg}, 8'h4F);
        else begin
          check("q13.an_tens", {6'd0, an}, 8'h02);
          check("q13.tens", {1'b0, seg}, 8'h06);
        end
      end
    end

    // Upstream counter 14,15,0: wrap only right after 0 is sampled.
    wrap_seen = 0;
    for (int i = 0; i < 3; i++) begin step(1'b0, 1'b0, 4'd14); check_model("w14"); wrap_seen += int'(wrap); end
    for (int i = 0; i < 3; i++) begin step(1'b0, 1'b0, 4'd15); check_model("w15"); wrap_seen += int'(wrap); end
    step(1'b0, 1'b0, 4'd0);
    check_model("w0");
    check("wrap.pulse", {7'd0, wrap}, 8'd1);
    check("wrap.chg",   {7'd0, chg},  8'd1);
    wrap_seen += int'(wrap);
    for (int i = 0; i < 3; i++) begin step(1'b0, 1'b0, 4'd0); check_model("w0b"); wrap_seen += int'(wrap); end
    check("wrap.count", wrap_seen[7:0], 8'd1);

    // hold while q_in moves 5 -> 9; display keeps 5, no chg until release.
    for (int i = 0; i < 3; i++) begin step(1'b0, 1'b0, 4'd5); check_model("h5"); end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 4'd9);
      check_model("hold");
      check("hold.chg", {7'd0, chg}, 8'd0);
      if (an == 2'b01) check("hold.seg5", {1'b0, seg}, 8'h6D);
    end
    step(1'b0, 1'b0, 4'd9);
    check_model("rel");
    check("rel.chg", {7'd0, chg}, 8'd1);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 4'd9);
      check_model("show9");
      if (an == 2'b01) check("show9.seg", {1'b0, seg}, 8'h6F);
    end

    // Reset while the tens slot is active.
    for (int i = 0; i < 2 * DIV && !(an == 2'b10 || (an == 2'b00 && e_tens_state)); i++) begin
      step(1'b0, 1'b0, 4'd12);
      check_model("pre_mid");
    end
    step(1'b1, 1'b0, 4'd12);
    check_model("midrst");
    check("midrst.an",    {6'd0, an}, 8'd0);
    check("midrst.seg",   {1'b0, seg}, 8'd0);
    check("midrst.state", {7'd0, (state_dbg == TENS)}, 8'd0);
    for (int i = 0; i < 2 * DIV + 2; i++) begin step(1'b0, 1'b0, 4'd12); check_model("post_mid"); end

    // Randomised: counter-like stream with jumps, hold bursts and rare resets.
    rq = 4'd0;
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 59) == 0);
      rh = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 1) == 0) rq = rq + 4'd1;
      step(rr, rh, rq);
      check_model("rnd");
      if (an == 2'b11) check("rnd.an_both", {6'd0, an}, 8'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
